// File: rtl/dpu_csr_pkg.sv
// rtl/dpu_csr_pkg.sv - DPU CSR address map, type codes and byte-swap helper
package dpu_csr_pkg;

  localparam logic [7:0] CSRA_VERSION  = 8'h00;
  localparam logic [7:0] CSRA_BUS      = 8'h10;
  localparam logic [7:0] CSRA_TYPE     = 8'h14;
  localparam logic [7:0] CSRA_BITS     = 8'h18;
  localparam logic [7:0] CSRA_PRESENT  = 8'h1C;
  localparam logic [7:0] CSRA_CTRL     = 8'h20;
  localparam logic [7:0] CSRA_STATUS   = 8'h24;
  localparam logic [7:0] CSRA_IRQ_STAT = 8'h28;
  localparam logic [7:0] CSRA_IRQ_EN   = 8'h2C;
  localparam logic [7:0] CSRA_SCRATCH  = 8'h30;
  localparam logic [2:0] CSRA_CNT_PAGE = 3'b010;

  localparam logic [15:0] TYPE_FP = 16'h4650;
  localparam logic [15:0] TYPE_FX = 16'h4658;
  localparam logic [15:0] TYPE_IT = 16'h4954;

  localparam int CTRL_CLR_BIT = 31;

  function automatic logic [15:0] swap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

endpackage

// File: rtl/dpu_csr_ctrl_if.sv
// rtl/dpu_csr_ctrl_if.sv - APB register bus between host bridge and the DPU CSR block
interface dpu_csr_ctrl_if #(
  parameter int APB_WIDTH_AD = 32,
  parameter int APB_WIDTH_DA = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic [APB_WIDTH_AD-1:0] PADDR;
  logic                    PWRITE;
  logic [APB_WIDTH_DA-1:0] PWDATA;
  logic [APB_WIDTH_DA-1:0] PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/dpu_run_counter.sv
// rtl/dpu_run_counter.sv - per-module busy-cycle counter, cleared on go, saturating at all-ones
module dpu_run_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        busy,
  output logic [31:0] count
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (go) cnt_d = '0;
    else if (busy && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/dpu_csr_ctrl.sv
// rtl/dpu_csr_ctrl.sv - DPU CSR block: ID registers, module start/busy/done, W1C irq, run counters
module dpu_csr_ctrl
  import dpu_csr_pkg::*;
#(
  parameter int          APB_WIDTH_AD = 32,
  parameter int          APB_WIDTH_DA = 32,
  parameter int          AXI_WIDTH_AD = 32,
  parameter int          AXI_WIDTH_DA = 32,
  parameter string       DATA_TYPE    = "FLOATING_POINT",
  parameter int          DATA_WIDTH   = 32,
  parameter int          DATA_WIDTH_Q = 16,
  parameter int          NUM_MOD      = 4,
  parameter logic [31:0] VERSION      = 32'h20250301
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  dpu_csr_ctrl_if.slave      apb,
  input  logic [NUM_MOD-1:0] mod_present,
  output logic [NUM_MOD-1:0] mod_go,
  input  logic [NUM_MOD-1:0] mod_busy,
  input  logic [NUM_MOD-1:0] mod_done,
  output logic               irq
);
  localparam bit          IS_FX     = (DATA_TYPE == "FIXED_POINT");
  localparam logic [15:0] TYPE_CODE = IS_FX ? TYPE_FX : (DATA_TYPE == "INTEGER") ? TYPE_IT : TYPE_FP;
  localparam logic [31:0] BUS_VAL   = {16'(AXI_WIDTH_AD), 16'(AXI_WIDTH_DA)};
  localparam logic [31:0] BITS_VAL  = {(IS_FX ? 16'(DATA_WIDTH_Q) : 16'h0), 16'(DATA_WIDTH)};

  logic [7:0]         addr;
  logic [2:0]         cnt_idx;
  logic               cnt_hit, mapped, ro, access, err, wr, wr_ctrl, clr_all;
  logic [31:0]        rd_val;
  logic [31:0]        cnt [8];
  logic [NUM_MOD-1:0] wmask;

  logic [31:0]        prdata_q, prdata_d, scratch_q, scratch_d;
  logic [NUM_MOD-1:0] go_q, go_d, stat_q, stat_d, en_q, en_d;
  logic               irq_q, irq_d;

  assign addr    = apb.PADDR[7:0];
  assign cnt_idx = addr[4:2];
  assign cnt_hit = (addr[7:5] == CSRA_CNT_PAGE) && (addr[1:0] == 2'b00) && (int'(cnt_idx) < NUM_MOD);
  assign wmask   = apb.PWDATA[NUM_MOD-1:0];

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    ro     = 1'b1;
    case (addr)
      CSRA_VERSION:  rd_val = VERSION;
      CSRA_BUS:      rd_val = BUS_VAL;
      CSRA_TYPE:     rd_val = {16'h0, swap(TYPE_CODE)};
      CSRA_BITS:     rd_val = BITS_VAL;
      CSRA_PRESENT:  rd_val = 32'(mod_present);
      CSRA_CTRL:     ro = 1'b0;
      CSRA_STATUS:   rd_val = 32'(mod_busy);
      CSRA_IRQ_STAT: begin rd_val = 32'(stat_q); ro = 1'b0; end
      CSRA_IRQ_EN:   begin rd_val = 32'(en_q);   ro = 1'b0; end
      CSRA_SCRATCH:  begin rd_val = scratch_q;   ro = 1'b0; end
      default: begin
        if (cnt_hit) rd_val = cnt[cnt_idx];
        else         mapped = 1'b0;
      end
    endcase
  end

  // Errored accesses never reach wr, so they have no side effects.
  always_comb begin
    access  = apb.PSEL & apb.PENABLE;
    err     = access & (~mapped | (apb.PWRITE & ro));
    wr      = access & apb.PWRITE & ~err;
    wr_ctrl = wr && (addr == CSRA_CTRL);
    clr_all = wr_ctrl & apb.PWDATA[CTRL_CLR_BIT];

    go_d = wr_ctrl ? (wmask & mod_present & ~mod_busy) : '0;

    stat_d = clr_all ? '0 : stat_q;
    if (wr && (addr == CSRA_IRQ_STAT)) stat_d = stat_d & ~wmask;
    stat_d = stat_d | mod_done;

    en_d      = (wr && (addr == CSRA_IRQ_EN))  ? wmask      : en_q;
    scratch_d = (wr && (addr == CSRA_SCRATCH)) ? apb.PWDATA : scratch_q;
    prdata_d  = (apb.PSEL && !apb.PWRITE)      ? rd_val     : '0;
    irq_d     = |(stat_q & en_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_q  <= '0;
      scratch_q <= '0;
      go_q      <= '0;
      stat_q    <= '0;
      en_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      prdata_q  <= prdata_d;
      scratch_q <= scratch_d;
      go_q      <= go_d;
      stat_q    <= stat_d;
      en_q      <= en_d;
      irq_q     <= irq_d;
    end
  end

  // Counters clear on the same edge that launches go, so they read 0 during the go cycle.
  for (genvar i = 0; i < 8; i++) begin : g_cnt
    if (i < NUM_MOD) begin : g_on
      dpu_run_counter u_cnt (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .go    (go_d[i] | clr_all),
        .busy  (mod_busy[i]),
        .count (cnt[i])
      );
    end else begin : g_off
      assign cnt[i] = '0;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;
  assign mod_go      = go_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_dpu_csr_ctrl.sv
// tb/tb_dpu_csr_ctrl.sv - scoreboard bench for dpu_csr_ctrl against a register-level reference model
module tb_dpu_csr_ctrl;
  localparam int NM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpu_csr_ctrl_if #(.APB_WIDTH_AD(32), .APB_WIDTH_DA(32)) apb_if ();
  logic [NM-1:0] present, busy, done;
  wire  [NM-1:0] go;
  wire           irq;

  dpu_csr_ctrl #(.NUM_MOD(NM)) dut (
    .PCLK        (clk),
    .PRESETn     (rst_n),
    .apb         (apb_if),
    .mod_present (present),
    .mod_go      (go),
    .mod_busy    (busy),
    .mod_done    (done),
    .irq         (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t          sbq[$];
  logic [NM-1:0] exp_go[int];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  longint        m_cnt[NM];
  logic [NM-1:0] m_stat, m_en;
  logic [31:0]   m_scratch;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every APB access phase is matched against the next scoreboard entry.
  always @(negedge clk) begin
    exp_t          e;
    logic [NM-1:0] eg;
    if (apb_if.PSEL && apb_if.PENABLE) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_access", 32'(apb_if.PADDR), 32'hDEAD_BEEF);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_rdata"}, apb_if.PRDATA, e.rdata);
        chk({e.name, "_slverr"}, 32'(apb_if.PSLVERR), 32'(e.err));
      end
    end
    eg = exp_go.exists(cyc) ? exp_go[cyc] : '0;
    if ((eg != '0) || (go != '0)) chk("mod_go", 32'(go), 32'(eg));
  end

  function automatic void model_reset();
    for (int i = 0; i < NM; i++) m_cnt[i] = 0;
    m_stat = '0;
    m_en = '0;
    m_scratch = '0;
  endfunction

  function automatic void model_access(input logic [7:0] a, input bit wr,
                                       output logic [31:0] rd, output bit err);
    bit ro = 1'b1;
    bit unmapped = 1'b0;
    rd = '0;
    case (a)
      8'h00: rd = 32'h2025_0301;
      8'h10: rd = 32'h0020_0020;
      8'h14: rd = 32'h0000_5046;
      8'h18: rd = 32'h0000_0020;
      8'h1C: rd = 32'(present);
      8'h20: ro = 1'b0;
      8'h24: rd = 32'(busy);
      8'h28: begin rd = 32'(m_stat); ro = 1'b0; end
      8'h2C: begin rd = 32'(m_en);   ro = 1'b0; end
      8'h30: begin rd = m_scratch;   ro = 1'b0; end
      8'h40, 8'h44, 8'h48, 8'h4C: rd = 32'(m_cnt[(a - 8'h40) / 4]);
      default: unmapped = 1'b1;
    endcase
    err = unmapped || (wr && ro);
  endfunction

  task automatic tick();
    for (int i = 0; i < NM; i++)
      if (busy[i] && rst_n && (m_cnt[i] < 64'hFFFF_FFFF)) m_cnt[i]++;
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [NM-1:0] done_acc, input string nm);
    exp_t          e;
    logic [31:0]   rd;
    bit            err;
    logic [NM-1:0] gm;
    model_access(a, wr, rd, err);
    e.name = nm;
    e.rdata = wr ? 32'h0 : rd;
    e.err = err;
    sbq.push_back(e);
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PADDR = {24'h0, a};
    apb_if.PWRITE = wr; apb_if.PWDATA = d;
    tick();
    apb_if.PENABLE = 1'b1;
    done = done_acc;
    tick();
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    done = '0;
    if (wr && !err) begin
      case (a)
        8'h20: begin
          gm = d[NM-1:0] & present & ~busy;
          if (d[31]) begin
            for (int i = 0; i < NM; i++) m_cnt[i] = 0;
            m_stat = '0;
          end
          for (int i = 0; i < NM; i++) if (gm[i]) m_cnt[i] = 0;
          if (gm != '0) exp_go[cyc] = gm;
        end
        8'h28: m_stat = m_stat & ~d[NM-1:0];
        8'h2C: m_en = d[NM-1:0];
        8'h30: m_scratch = d;
        default: ;
      endcase
    end
    m_stat = m_stat | done_acc;
  endtask

  task automatic rd(input logic [7:0] a, input string nm);
    apb_xfer(1'b0, a, 32'h0, '0, nm);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
    apb_xfer(1'b1, a, d, '0, nm);
  endtask

  task automatic pulse_done(input logic [NM-1:0] m);
    done = m;
    tick();
    done = '0;
    m_stat = m_stat | m;
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < 8'h60; a += 4) rd(8'(a), nm);
  endtask

  function automatic logic [7:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 23) * 4);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PADDR = '0;
    apb_if.PWRITE = 1'b0; apb_if.PWDATA = '0;
    present = 4'b0111; busy = '0; done = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_go", 32'(go), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_prdata", apb_if.PRDATA, 32'h0);
    chk("rst_slverr", 32'(apb_if.PSLVERR), 32'h0);
    chk("rst_pready", 32'(apb_if.PREADY), 32'h1);
    rst_n = 1'b1;
    tick();

    read_all("id_rd");

    wr(8'h20, 32'h1, "go0");
    chk("go0_pulse", 32'(go), 32'h1);
    tick();
    chk("go0_one_cycle", 32'(go), 32'h0);
    busy[0] = 1'b1;
    wr(8'h20, 32'h1, "go0_busy");
    chk("go0_dropped_busy", 32'(go), 32'h0);
    busy[0] = 1'b0;
    wr(8'h20, 32'h8, "go3_absent");
    chk("go3_dropped_absent", 32'(go), 32'h0);
    wr(8'h20, 32'hF0, "go_high_bits");

    wr(8'h20, 32'h2, "go1");
    busy[1] = 1'b1;
    repeat (10) tick();
    busy[1] = 1'b0;
    rd(8'h44, "cnt1_ten");
    chk("cnt1_model_ten", 32'(m_cnt[1]), 32'd10);

    force dut.g_cnt[1].g_on.u_cnt.cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.g_cnt[1].g_on.u_cnt.cnt_q;
    m_cnt[1] = 64'hFFFF_FFFE;
    busy[1] = 1'b1;
    repeat (3) tick();
    busy[1] = 1'b0;
    rd(8'h44, "cnt1_sat");

    wr(8'h2C, 32'h4, "en4");
    pulse_done(4'b0100);
    chk("irq_not_yet", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    rd(8'h28, "stat4");
    wr(8'h28, 32'h4, "w1c4");
    tick();
    chk("irq_cleared", 32'(irq), 32'h0);

    pulse_done(4'b0001);
    apb_xfer(1'b1, 8'h28, 32'h1, 4'b0001, "w1c_vs_set");
    rd(8'h28, "stat_set_wins");

    wr(8'h00, 32'hFFFF_FFFF, "wr_ro_version");
    rd(8'h3C, "rd_unmapped_3c");
    rd(8'h50, "rd_cnt4");
    wr(8'h44, 32'h1234, "wr_ro_cnt");
    wr(8'h24, 32'hF, "wr_ro_status");
    rd(8'h21, "rd_misaligned");
    read_all("after_err_rd");

    busy[2] = 1'b1;
    wr(8'h20, 32'h1, "go0_run");
    repeat (5) tick();
    pulse_done(4'b0110);
    busy[2] = 1'b0;
    wr(8'h20, 32'h8000_0000, "clr_all");
    read_all("after_clr_rd");
    pulse_done(4'b0010);
    wr(8'h20, 32'h8000_0005, "clr_and_go");
    chk("clr_and_go_pulse", 32'(go), 32'h5);
    read_all("after_clr_go_rd");

    for (int it = 0; it < 80; it++) begin
      busy = 4'($urandom);
      case ($urandom_range(0, 6))
        0: wr(8'h30, $urandom, "rnd_scratch");
        1: wr(8'h2C, $urandom, "rnd_en");
        2: apb_xfer(1'b1, 8'h28, $urandom, 4'($urandom), "rnd_w1c");
        3: wr(8'h20, {($urandom_range(0, 7) == 0), 27'h0, 4'($urandom)}, "rnd_ctrl");
        4: pulse_done(4'($urandom));
        5: rd(rnd_addr(), "rnd_rd");
        default: wr(rnd_addr(), $urandom, "rnd_wr");
      endcase
      tick();
      chk("rnd_irq", 32'(irq), 32'(|(m_stat & m_en)));
    end
    busy = '0;
    read_all("rnd_final_rd");

    wr(8'h30, 32'hA5A5_5A5A, "pre_rst_scratch");
    wr(8'h2C, 32'hF, "pre_rst_en");
    pulse_done(4'b0011);
    tick();
    chk("pre_rst_irq", 32'(irq), 32'h1);
    busy[1] = 1'b1;
    wr(8'h20, 32'h5, "pre_rst_go");
    #2;
    exp_go.delete(cyc);
    rst_n = 1'b0;
    #1;
    chk("async_rst_go", 32'(go), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_prdata", apb_if.PRDATA, 32'h0);
    model_reset();
    busy = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_go", 32'(go), 32'h0);
    read_all("post_rst_rd");

    tick();
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
